cix_seq: RTL and testbench



---
 rtl/cix_seq.sv | 139 +++++++++++++
 tb/tb_cix_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cix_seq.sv
// Multi-cycle bit-count sequencer: scans a W-bit operand one 2^ORDER-bit slice per
// cycle through an internal cix slice, giving clz/ctz (early exit) or zero popcount.
module cix_seq #(
  parameter int unsigned ORDER = 3,
  parameter int unsigned STEPS = 2,
  localparam int unsigned W  = 2**(ORDER+STEPS),
  localparam int unsigned CW = ORDER+STEPS+1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_top,
  input  logic          req_bot,
  input  logic          req_inv,
  input  logic [W-1:0]  req_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_count,
  output logic          res_zero
);

  localparam int unsigned S = 2**ORDER;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_sh;
  logic [CW-1:0]   r_acc;
  logic [STEPS-1:0] r_step;
  logic            r_top;
  logic            r_bot;
  logic            r_zero;

  logic [W-1:0]    w_d;
  logic [S-1:0]    w_slice;
  logic [S-1:0]    w_tmp;
  logic [ORDER:0]  w_cnt;
  logic            w_found;
  logic            w_ctz;
  logic            w_last;
  logic            w_accept;

  assign w_d      = req_inv ? ~req_data : req_data;
  assign w_ctz    = !r_top && r_bot;
  assign w_slice  = w_ctz ? r_sh[S-1:0] : r_sh[W-1:W-S];
  assign w_accept = req_valid && req_ready;

  // Internal cix slice: leading/trailing zero count or zero population of one slice.
  always_comb begin
    w_tmp   = w_slice;
    w_found = 1'b0;
    w_cnt   = '0;
    case ({r_top, r_bot})
      2'b10: begin
        for (int unsigned i = 0; i < S; i++) begin
          if (!w_found) begin
            if (w_tmp[S-1]) w_found = 1'b1;
            else            w_cnt   = w_cnt + (ORDER+1)'(1);
          end
          w_tmp = w_tmp << 1;
        end
      end
      2'b01: begin
        for (int unsigned i = 0; i < S; i++) begin
          if (!w_found) begin
            if (w_tmp[0]) w_found = 1'b1;
            else          w_cnt   = w_cnt + (ORDER+1)'(1);
          end
          w_tmp = w_tmp >> 1;
        end
      end
      2'b11: begin
        for (int unsigned i = 0; i < S; i++) begin
          if (!w_tmp[S-1]) w_cnt = w_cnt + (ORDER+1)'(1);
          w_tmp = w_tmp << 1;
        end
      end
      default: w_cnt = '0;
    endcase
  end

  // Reserved op stops after one cycle; clz/ctz stop on the first non-zero slice.
  assign w_last = ({r_top, r_bot} == 2'b00) ||
                  ((r_top ^ r_bot) && (|w_slice)) ||
                  (r_step == '1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    res_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sh   <= '0;
      r_acc  <= '0;
      r_step <= '0;
      r_top  <= 1'b0;
      r_bot  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_sh   <= w_d;
      r_top  <= req_top;
      r_bot  <= req_bot;
      r_acc  <= '0;
      r_step <= '0;
      r_zero <= (w_d == '0);
    end else if (r_state == ST_RUN) begin
      r_acc  <= r_acc + CW'(w_cnt);
      r_sh   <= w_ctz ? (r_sh >> S) : (r_sh << S);
      r_step <= r_step + STEPS'(1);
    end
  end

  assign res_count = r_acc;
  assign res_zero  = r_zero;

endmodule

// File: tb/tb_cix_seq.sv
// Scoreboard bench for cix_seq (ORDER=3, STEPS=2, W=32): a bit-level reference
// model pushes expected count/zero/latency; results are popped as the DUT delivers them.
module tb_cix_seq;

  localparam int unsigned ORDER = 3;
  localparam int unsigned STEPS = 2;
  localparam int unsigned W     = 32;
  localparam int unsigned CW    = 6;

  logic          clock;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_top;
  logic          req_bot;
  logic          req_inv;
  logic [W-1:0]  req_data;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_count;
  logic          res_zero;

  typedef struct {
    int unsigned cnt;
    int unsigned zero;
    int unsigned k;
  } exp_t;

  exp_t sb[$];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  cix_seq #(.ORDER(ORDER), .STEPS(STEPS)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_top   (req_top),
    .req_bot   (req_bot),
    .req_inv   (req_inv),
    .req_data  (req_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_count (res_count),
    .res_zero  (res_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Bit-level reference, independent of slicing except for the latency rule.
  function automatic exp_t model(input logic top, input logic bot, input logic inv,
                                 input logic [W-1:0] data);
    exp_t         e;
    logic [W-1:0] d;
    bit           found;
    d      = inv ? ~data : data;
    e.zero = (d == '0) ? 1 : 0;
    e.cnt  = 0;
    found  = 0;
    case ({top, bot})
      2'b11: begin
        for (int i = 0; i < W; i++) if (!d[i]) e.cnt++;
        e.k = 4;
      end
      2'b10: begin
        for (int i = W-1; i >= 0; i--) begin
          if (d[i]) found = 1;
          else if (!found) e.cnt++;
        end
        e.k = (e.cnt >= W) ? 4 : e.cnt / 8 + 1;
      end
      2'b01: begin
        for (int i = 0; i < W; i++) begin
          if (d[i]) found = 1;
          else if (!found) e.cnt++;
        end
        e.k = (e.cnt >= W) ? 4 : e.cnt / 8 + 1;
      end
      default: e.k = 1;
    endcase
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_req(input string tag, input logic top, input logic bot,
                         input logic inv, input logic [W-1:0] data, input int unsigned hold);
    exp_t          e;
    int unsigned   cyc;
    logic [CW-1:0] held;
    sb.push_back(model(top, bot, inv, data));
    chk({tag, "_idle_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_top   = top;
    req_bot   = bot;
    req_inv   = inv;
    req_data  = data;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    req_data  = $urandom();
    req_inv   = ~inv;
    cyc = 0;
    while (!res_valid && cyc < 20) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
    end
    chk({tag, "_res_valid"}, res_valid, 1);
    e = sb.pop_front();
    chk({tag, "_latency"}, cyc, e.k);
    chk({tag, "_count"}, res_count, e.cnt);
    chk({tag, "_zero"}, res_zero, e.zero);
    held = res_count;
    repeat (hold) begin
      @(posedge clock);
      @(negedge clock);
      chk({tag, "_bp_valid"}, res_valid, 1);
      chk({tag, "_bp_req_ready"}, req_ready, 0);
      chk({tag, "_bp_count"}, res_count, held);
    end
    res_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    res_ready = 1'b0;
    chk({tag, "_valid_drop"}, res_valid, 0);
    chk({tag, "_ready_back"}, req_ready, 1);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_top   = 1'b0;
    req_bot   = 1'b0;
    req_inv   = 1'b0;
    req_data  = '0;
    res_ready = 1'b0;
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_count", res_count, 0);
    chk("rst_res_zero", res_zero, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    run_req("clz_0001",  1, 0, 0, 32'h0001_0000, 0);
    run_req("ctz_0080",  0, 1, 0, 32'h0000_0080, 0);
    run_req("ctz_zero",  0, 1, 0, 32'h0000_0000, 0);
    run_req("pop_f0f0",  1, 1, 0, 32'hF0F0_F0F0, 0);
    run_req("pop1_fffe", 1, 1, 1, 32'hFFFF_FFFE, 0);
    run_req("pop1_zero", 1, 1, 1, 32'h0000_0000, 0);
    run_req("pop1_ones", 1, 1, 1, 32'hFFFF_FFFF, 0);
    run_req("clz_bp",    1, 0, 0, 32'h8000_0000, 5);
    run_req("rsvd",      0, 0, 0, 32'h1234_5678, 0);
    run_req("clo",       1, 0, 1, 32'hFFF0_0000, 0);
    run_req("cto",       0, 1, 1, 32'h0000_FFFF, 1);
    run_req("clz_last",  1, 0, 0, 32'h0000_0001, 0);

    // Asynchronous reset in the middle of a popcount.
    req_valid = 1'b1;
    req_top   = 1'b1;
    req_bot   = 1'b1;
    req_inv   = 1'b0;
    req_data  = 32'h0F0F_0F0F;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_req_ready", req_ready, 1);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_res_count", res_count, 0);
    chk("arst_res_zero", res_zero, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    run_req("ctz_after_rst", 0, 1, 0, 32'h0000_0100, 0);

    for (int i = 0; i < 6; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(1, 3));
      run_req("rand", op[1], op[0], 1'($urandom_range(0, 1)), $urandom() >> $urandom_range(0, 31), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
